// File: rtl/pattern_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
// Holds the FSM state enum, default sizes and the reference test word.
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } tx_state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_GAP_CYCLES = 1;

  localparam logic [15:0] PAT_DEFAULT = 16'h5772;

  // Counter width for n states, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Up/down counter with clear, load, enable and terminal-count flag.
// Ports: clk, rst (async active-low), clr, load, ld_val, en, tc.
module bit_counter
  import pattern_pkg::*;
#(
  parameter int           W    = 4,
  parameter bit           DOWN = 1'b0,
  parameter logic [W-1:0] TERM = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= ld_val;
    end else if (en) begin
      q <= DOWN ? q - 1'b1 : q + 1'b1;
    end
  end

  assign tc = (q == TERM);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial transmitter: parallel word in by valid/ready, LSB first out.
// Ports: clk, rst, in_data/in_valid/in_ready, hold, outp, out_valid, busy, done.
module serial_pattern_tx
  import pattern_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hold,
  output logic             outp,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = cnt_w(GAP_CYCLES);

  localparam logic [CW-1:0] LAST =
    CW'(WIDTH - 1);
  localparam logic [GW-1:0] GLOAD =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_t        state;
  logic [WIDTH-1:0] sreg;

  logic accept;
  logic step;
  logic last;
  logic cnt_tc;
  logic gap_tc;
  logic gap_en;

  assign accept = in_valid && (state == IDLE);
  assign step   = (state == SHIFT) && !hold;
  assign last   = step && cnt_tc;
  // Park the gap counter at zero instead of wrapping.
  assign gap_en = (state == GAP) && !gap_tc;

  // Cleared after the last bit so it rests at zero in IDLE.
  bit_counter #(
    .W    (CW),
    .DOWN (1'b0),
    .TERM (LAST)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept || last),
    .load   (1'b0),
    .ld_val ('0),
    .en     (step),
    .tc     (cnt_tc)
  );

  bit_counter #(
    .W    (GW),
    .DOWN (1'b1),
    .TERM ('0)
  ) u_gap (
    .clk    (clk),
    .rst    (rst),
    .clr    (1'b0),
    .load   (last),
    .ld_val (GLOAD),
    .en     (gap_en),
    .tc     (gap_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state <= SHIFT;
            sreg  <= in_data;
          end
        end
        SHIFT: begin
          if (step) begin
            sreg <= sreg >> 1;
            if (cnt_tc) begin
              state <= (GAP_CYCLES > 0) ? GAP : IDLE;
            end
          end
        end
        GAP: begin
          if (gap_tc) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from registered state; only out_valid/done see hold.
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign outp      = (state == SHIFT) && sreg[0];
  assign out_valid = step;
  assign done      = last;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx.
// Directed vector table, corner sequences and a randomized scoreboard.
module tb_serial_pattern_tx;
  import pattern_pkg::*;

  localparam int W = 16;
  localparam int GAP = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         hold = 1'b0;
  logic         in_ready, outp, out_valid, busy, done;
  logic [W-1:0] in_data0 = '0;
  logic         in_valid0 = 1'b0;
  logic         hold0 = 1'b0;
  logic         in_ready0, outp0, out_valid0, busy0, done0;

  serial_pattern_tx #(.WIDTH(W), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .hold(hold), .outp(outp), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  serial_pattern_tx #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .hold(hold0), .outp(outp0), .out_valid(out_valid0),
    .busy(busy0), .done(done0)
  );

  always #5 clk = ~clk;

  // {outp, out_valid, done, in_ready, busy}
  wire [4:0] obs  = {outp, out_valid, done, in_ready, busy};
  wire [4:0] obs0 = {outp0, out_valid0, done0, in_ready0, busy0};

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       iv;
    logic       hd;
    logic [4:0] e;
  } vec_t;

  vec_t tv[19];
  bit   pb[16] = '{0,1,0,0,1,1,1,0,1,1,1,0,1,0,1,0};

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Overlapping Mealy "1011" detector over a bit stream.
  function automatic logic [15:0] det(input logic [15:0] s);
    logic [15:0] r = '0;
    for (int i = 3; i < 16; i++)
      r[i] = s[i-3] && !s[i-2] && s[i-1] && s[i];
    return r;
  endfunction

  task automatic run_word(input logic [15:0] d,
                          input int hs,
                          input int hl,
                          input string nm);
    int  k = 0;
    int  held = 0;
    int  c = 0;
    logic h;
    in_data  = d;
    in_valid = 1'b1;
    hold     = 1'b0;
    smp();
    chk({nm, "_hs"}, 32'(obs), 32'(5'b00010));
    nxt();
    in_valid = 1'b0;
    while (k < 16) begin
      h = (k == hs) && (held < hl);
      hold = h;
      smp();
      chk($sformatf("%s_c%0d", nm, c), 32'(obs),
          32'({d[k], !h, !h && (k == 15), 1'b0, 1'b1}));
      if (h) held++;
      else k++;
      c++;
      nxt();
    end
    hold = 1'b0;
    smp();
    chk({nm, "_gap"}, 32'(obs), 32'(5'b00001));
    nxt();
    smp();
    chk({nm, "_idle"}, 32'(obs), 32'(5'b00010));
    nxt();
  endtask

  task automatic rnd_test();
    bit   bq[$];
    bit   lq[$];
    int   since = 100;
    logic erdy, eov, b, l, hs;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc < 2940) begin
        hold = ($urandom_range(0, 3) == 0);
        if (!in_valid && $urandom_range(0, 2) == 0) begin
          in_valid = 1'b1;
          in_data  = W'($urandom);
        end
      end else begin
        hold = 1'b0;
      end
      smp();
      since++;
      erdy = (bq.size() == 0) && (since > GAP);
      eov  = !hold && (bq.size() > 0);
      chk("rnd_rdy", 32'(in_ready), 32'(erdy));
      chk("rnd_busy", 32'(busy), 32'(!erdy));
      chk("rnd_ov", 32'(out_valid), 32'(eov));
      if (out_valid && bq.size() > 0) begin
        b = bq.pop_front();
        l = lq.pop_front();
        chk("rnd_bit", 32'(outp), 32'(b));
        chk("rnd_done", 32'(done), 32'(l));
        if (done) since = 0;
      end else begin
        chk("rnd_nodone", 32'(done), 32'(0));
      end
      if (!busy) chk("rnd_outp0", 32'(outp), 32'(0));
      hs = in_valid && in_ready;
      if (hs) begin
        for (int i = 0; i < W; i++) begin
          bq.push_back(in_data[i]);
          lq.push_back(i == W - 1);
        end
      end
      nxt();
      if (hs) in_valid = 1'b0;
    end
    chk("rnd_drain", 32'(bq.size()), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] cap;
    logic [15:0] pbv;
    logic [15:0] wd;
    int          ncap;
    int          p;

    rst = 1'b0;
    repeat (2) nxt();
    smp();
    chk("reset", 32'(obs), 32'(5'b00010));
    chk("reset0", 32'(obs0), 32'(5'b00010));
    nxt();
    rst = 1'b1;
    nxt();

    tv[0] = '{1'b1, 1'b0, 5'b00010};
    for (int k = 0; k < 16; k++)
      tv[k+1] = '{1'b0, 1'b0,
                  {pb[k], 1'b1, (k == 15), 1'b0, 1'b1}};
    tv[17] = '{1'b0, 1'b0, 5'b00001};
    tv[18] = '{1'b0, 1'b0, 5'b00010};

    cap  = '0;
    ncap = 0;
    in_data = PAT_DEFAULT;
    for (int i = 0; i < 19; i++) begin
      in_valid = tv[i].iv;
      hold     = tv[i].hd;
      smp();
      chk($sformatf("vec%0d", i), 32'(obs), 32'(tv[i].e));
      if (out_valid && ncap < 16) begin
        cap[ncap] = outp;
        ncap++;
      end
      nxt();
    end
    for (int k = 0; k < 16; k++) pbv[k] = pb[k];
    chk("det_len", 32'(ncap), 32'(16));
    chk("det_seq", 32'(det(cap)), 32'(det(pbv)));

    run_word(PAT_DEFAULT, 6, 3, "hold5");
    run_word(PAT_DEFAULT, 15, 2, "holdlast");

    in_data  = 16'hFFFF;
    in_valid = 1'b1;
    smp();
    nxt();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      smp();
      chk($sformatf("ffff_b%0d", k), 32'(outp), 32'(1));
      nxt();
    end
    rst = 1'b0;
    #1;
    chk("rst_mid", 32'(obs), 32'(5'b00010));
    smp();
    chk("rst_hold", 32'(obs), 32'(5'b00010));
    nxt();
    rst = 1'b1;
    nxt();
    run_word(16'h0001, -1, 0, "postrst");

    in_data0  = 16'hA5A5;
    in_valid0 = 1'b1;
    for (int c = 0; c < 35; c++) begin
      if (c == 1) in_data0 = 16'h3C3C;
      if (c == 34) in_valid0 = 1'b0;
      smp();
      p  = c % 17;
      wd = (c < 17) ? 16'hA5A5 : 16'h3C3C;
      if (p == 0)
        chk($sformatf("b2b_c%0d", c), 32'(obs0),
            32'(5'b00010));
      else
        chk($sformatf("b2b_c%0d", c), 32'(obs0),
            32'({wd[p-1], 1'b1, (p == 16), 1'b0, 1'b1}));
      nxt();
    end

    rnd_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
